cic_interp_core: RTL and testbench



---
 rtl/cic_interp_core.sv | 188 ++++++++++++++++++
 tb/tb_cic_interp_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_core.sv
// cic_interp_core: CIC interpolator for the DAC/result stream.
// N comb stages at the input rate, zero-stuff upsampling by R = 2**LOG2_R, then N integrator
// stages at the output rate. All internal arithmetic is OUT_WIDTH bits and wraps on purpose;
// the final integrator result is exact modulo 2**OUT_WIDTH, which is all a CIC needs.
// Optional build macro: CIC_GAIN_NORM_EN -- registers acc_N >>> (N-1)*LOG2_R in an extra output
// stage for unity DC gain (one more cycle of latency). Undefined: raw gain R**(N-1).
module cic_interp_core #(
    parameter int IN_WIDTH = 16,
    parameter int N        = 3,
    parameter int LOG2_R   = 2,
    localparam int OUT_WIDTH = IN_WIDTH + (N - 1) * LOG2_R
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic                        o_valid,
    output logic                        o_busy
);

    localparam int R = 1 << LOG2_R;
    localparam logic [LOG2_R-1:0] PHASE_LAST    = LOG2_R'(R - 1);
    localparam logic [LOG2_R-1:0] PHASE_PRELAST = LOG2_R'(R - 2);

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef logic signed [OUT_WIDTH-1:0] word_t;

    // Generator state
    state_e              state_q;
    logic [LOG2_R-1:0]   phase_q;
    logic                ready_q;
    word_t               u_data_q;
    logic                u_valid_q;

    // Comb chain: comb_c[0] is the sign-extended input, comb_c[N] feeds the upsampler
    word_t               comb_c [N+1];
    word_t               comb_dly_q [N];

    // Integrator chain
    word_t               acc_q [N];
    word_t               acc_d [N];
    logic  [N-1:0]       int_valid_q;
    logic  [N-1:0]       int_valid_d;

    logic                accept;

    assign accept  = i_valid && ready_q;
    assign o_ready = ready_q;

    // Combinational comb differences, evaluated against the delays of the previous accept
    always_comb begin
        comb_c[0] = word_t'(i_data);
        for (int k = 0; k < N; k++) begin
            comb_c[k+1] = comb_c[k] - comb_dly_q[k];
        end
    end

    // Comb delays advance only on an accepted input sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                comb_dly_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                comb_dly_q[k] <= comb_c[k];
            end
        end
    end

    // Zero-stuff generator: one comb output followed by R-1 zeros; ready is registered and
    // rises in the last phase so a waiting input continues the output stream without a gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            ready_q   <= 1'b1;
            u_data_q  <= '0;
            u_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        u_data_q  <= comb_c[N];
                        u_valid_q <= 1'b1;
                        phase_q   <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= StRun;
                    end else begin
                        u_data_q  <= '0;
                        u_valid_q <= 1'b0;
                        ready_q   <= 1'b1;
                    end
                end
                StRun: begin
                    if (phase_q != PHASE_LAST) begin
                        u_data_q  <= '0;
                        u_valid_q <= 1'b1;
                        phase_q   <= phase_q + LOG2_R'(1);
                        ready_q   <= (phase_q == PHASE_PRELAST);
                    end else if (accept) begin
                        u_data_q  <= comb_c[N];
                        u_valid_q <= 1'b1;
                        phase_q   <= '0;
                        ready_q   <= 1'b0;
                    end else begin
                        u_data_q  <= '0;
                        u_valid_q <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    phase_q   <= '0;
                    ready_q   <= 1'b1;
                    u_data_q  <= '0;
                    u_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Integrator next state: a stage only accumulates when its input is valid, so idle
    // gaps travel down the chain as bubbles and leave the accumulators untouched
    always_comb begin
        for (int k = 0; k < N; k++) begin
            acc_d[k]       = acc_q[k];
            int_valid_d[k] = 1'b0;
        end
        if (u_valid_q) begin
            acc_d[0]       = acc_q[0] + u_data_q;
            int_valid_d[0] = 1'b1;
        end
        for (int k = 1; k < N; k++) begin
            if (int_valid_q[k-1]) begin
                acc_d[k]       = acc_q[k] + acc_q[k-1];
                int_valid_d[k] = 1'b1;
            end
        end
    end

    // Integrator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= '0;
            end
            int_valid_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= acc_d[k];
            end
            int_valid_q <= int_valid_d;
        end
    end

`ifdef CIC_GAIN_NORM_EN
    localparam int NORM_SHIFT = (N - 1) * LOG2_R;

    word_t out_data_q;
    logic  out_valid_q;

    // Gain normalisation stage: arithmetic shift keeps the sign of the wrapped result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= int_valid_q[N-1];
            if (int_valid_q[N-1]) begin
                out_data_q <= acc_q[N-1] >>> NORM_SHIFT;
            end
        end
    end

    assign o_data  = out_data_q;
    assign o_valid = out_valid_q;
    assign o_busy  = (state_q == StRun) | u_valid_q | (|int_valid_q) | out_valid_q;
`else
    assign o_data  = acc_q[N-1];
    assign o_valid = int_valid_q[N-1];
    assign o_busy  = (state_q == StRun) | u_valid_q | (|int_valid_q);
`endif

endmodule

// File: tb/tb_cic_interp_core.sv
// Scoreboard bench for cic_interp_core at IN_WIDTH=16, N=3, LOG2_R=2 (OUT_WIDTH=20).
// Expected outputs come from a direct convolution of the accepted inputs with the hand-derived
// interpolator impulse response, reduced modulo 2**20, each tagged with its expected cycle.
module tb_cic_interp_core;

    localparam int IW = 16;
    localparam int OW = 20;
`ifdef CIC_GAIN_NORM_EN
    localparam int LAT    = 4;
    localparam int SH     = 4;
    localparam int DC_EXP = 100;
    localparam int WR_EXP = -32768;
`else
    localparam int LAT    = 3;
    localparam int SH     = 0;
    localparam int DC_EXP = 1600;
    localparam int WR_EXP = -524288;
`endif
    localparam int HCOEF [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

    typedef struct {
        logic signed [OW-1:0] val;
        int                   cyc;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic signed [IW-1:0] i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic signed [OW-1:0] o_data;
    logic                 o_valid;
    logic                 o_busy;

    exp_t   exp_q [$];
    longint xs [$];
    int     ncyc;
    int     n_checks;
    int     n_pass;

    cic_interp_core #(
        .IN_WIDTH(IW),
        .N(3),
        .LOG2_R(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ncyc = 0;
    always @(negedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    endtask

    function automatic longint model_out(input int n);
        longint s = 0;
        for (int j = 0; j < xs.size(); j++) begin
            int t = n - 4 * j;
            if (t >= 0 && t < 10) s += xs[j] * longint'(HCOEF[t]);
        end
        return s;
    endfunction

    // Issue one sample; scramble drives junk on i_data while the core is not ready
    task automatic send(input int v, input int exp_wait, input bit scramble);
        int waitc = 0;
        int acc_id;
        int m;
        longint y;
        logic signed [OW-1:0] w;
        i_valid = 1'b1;
        i_data  = IW'(v);
        while (!o_ready && waitc < 20) begin
            if (scramble) i_data = IW'($urandom);
            @(posedge clk);
            #1;
            waitc++;
        end
        if (exp_wait >= 0) chk("ready_wait", waitc, exp_wait);
        if (!o_ready) begin
            chk("ready_timeout", o_ready, 1);
            i_valid = 1'b0;
            return;
        end
        i_data = IW'(v);
        @(posedge clk);
        acc_id = ncyc;
        xs.push_back(longint'(v));
        m = xs.size() - 1;
        for (int p = 0; p < 4; p++) begin
            y = model_out(4 * m + p);
            w = y[OW-1:0];
            w = w >>> SH;
            exp_q.push_back('{val: w, cyc: acc_id + LAT + p});
        end
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst     = 1'b1;
        i_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q.delete();
        xs.delete();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_ready", o_ready, 1);
        chk("rst_o_busy", o_busy, 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: every valid output must match the head of the scoreboard, on the right cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", o_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", o_data, e.val);
                    chk("out_cycle", ncyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;

        do_reset(10);

        // Impulse, back-to-back, with junk on i_data during one not-ready window
        send(1, 0, 1'b0);
        send(0, 3, 1'b0);
        send(0, 3, 1'b1);
        send(0, 3, 1'b0);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("impulse_idle_busy", o_busy, 0);

        // DC gain
        do_reset(2);
        for (int i = 0; i < 20; i++) send(100, (i == 0) ? 0 : 3, 1'b0);
        drain();
        chk("dc_settle", o_data, DC_EXP);

        // Full-scale negative DC exercises the wrap-around range
        do_reset(2);
        for (int i = 0; i < 20; i++) send(-32768, (i == 0) ? 0 : 3, 1'b0);
        drain();
        chk("wrap_settle", o_data, WR_EXP);

        // Alternating full-scale input
        do_reset(2);
        for (int i = 0; i < 16; i++) send((i % 2) ? -32768 : 32767, (i == 0) ? 0 : 3, 1'b0);
        drain();

        // Reset in the middle of a burst discards everything in flight
        do_reset(2);
        send(5, 0, 1'b0);
        send(7, 3, 1'b0);
        do_reset(1);

        // Gapped impulse: same coefficients, core goes idle between inputs
        send(1, 0, 1'b0);
        chk("gap_busy_high", o_busy, 1);
        for (int g = 0; g < 3; g++) begin
            repeat (10) @(posedge clk);
            #1;
            chk("gap_busy_low", o_busy, 0);
            chk("gap_ready", o_ready, 1);
            send(0, 0, 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
